// File: rtl/lc3_periph_pkg.sv
// Shared LC3 peripheral definitions: SCLER bit map, SCL generator state encoding, default divider.
package lc3_periph_pkg;

    localparam int SCLER_EN         = 0;
    localparam int SCLER_STRETCH_EN = 1;
    localparam int SCLER_BUSY       = 2;
    localparam int SCLER_STRETCHED  = 3;
    localparam int SCLER_STRETCHING = 4;

    localparam logic [15:0] SCL_DEFAULT_DIV = 16'h01F4;

    typedef enum logic [1:0] {
        SCL_IDLE    = 2'd0,
        SCL_HIGH    = 2'd1,
        SCL_LOW     = 2'd2,
        SCL_WAIT_HI = 2'd3
    } scl_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop level synchroniser for an asynchronous input; latency STAGES clk, no backpressure.
// Flops reset to RST_VAL so an idle-high line reads high straight out of reset.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage <= {STAGES{RST_VAL}};
        end else begin
            stage <= {stage[STAGES-2:0], d};
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/scl_clkgen.sv
// Programmable SCL generator with slave clock stretching and glitch-free enable; strobes are registered.
// Half-period = max(SCLDIV,2) clk; a stretching slave holds the high phase off until SCL is seen high.
module scl_clkgen
    import lc3_periph_pkg::*;
#(
    parameter int               DIV_W       = 16,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(SCL_DEFAULT_DIV),
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      MDR,
    input  logic             LD_SCLER,
    input  logic             LD_SCLDIV,
    input  logic             SCL_IN,
    output logic             SCL_OE,
    output logic             SCL_BUS,
    output logic [15:0]      SCLER,
    output logic [DIV_W-1:0] SCLDIV,
    output logic             WR,
    output logic             scl_rise,
    output logic             scl_fall,
    output logic             scl_sample
);

    scl_state_t       state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_cur;
    logic [DIV_W-1:0] div_eff;
    logic             en;
    logic             stretch_en;
    logic             stretched;
    logic             stretching;
    logic             scl_sync;
    logic             term;

    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (SCL_IN),
        .q       (scl_sync)
    );

    assign div_eff    = (SCLDIV < DIV_W'(2)) ? DIV_W'(2) : SCLDIV;
    assign term       = (cnt == div_cur - DIV_W'(1));
    assign stretching = (state == SCL_WAIT_HI) && !scl_sync;
    assign SCL_BUS    = ~SCL_OE;

    always_comb begin
        SCLER                   = '0;
        SCLER[SCLER_EN]         = en;
        SCLER[SCLER_STRETCH_EN] = stretch_en;
        SCLER[SCLER_BUSY]       = (state != SCL_IDLE);
        SCLER[SCLER_STRETCHED]  = stretched;
        SCLER[SCLER_STRETCHING] = stretching;
    end

    // A stretch seen in the same cycle as a clear-sticky write wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en         <= 1'b0;
            stretch_en <= 1'b0;
            stretched  <= 1'b0;
            SCLDIV     <= DEFAULT_DIV;
            WR         <= 1'b0;
        end else begin
            WR <= LD_SCLER | LD_SCLDIV;
            if (LD_SCLER) begin
                en         <= MDR[SCLER_EN];
                stretch_en <= MDR[SCLER_STRETCH_EN];
            end
            if (LD_SCLDIV) begin
                SCLDIV <= MDR[DIV_W-1:0];
            end
            if (stretching) begin
                stretched <= 1'b1;
            end else if (LD_SCLER && MDR[SCLER_STRETCHED]) begin
                stretched <= 1'b0;
            end
        end
    end

    // Divider is latched into div_cur on every half-period entry so mid-phase writes wait a phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SCL_IDLE;
            cnt        <= '0;
            div_cur    <= DEFAULT_DIV;
            SCL_OE     <= 1'b0;
            scl_rise   <= 1'b0;
            scl_fall   <= 1'b0;
            scl_sample <= 1'b0;
        end else begin
            scl_rise   <= 1'b0;
            scl_fall   <= 1'b0;
            scl_sample <= 1'b0;
            case (state)
                SCL_IDLE: begin
                    if (en) begin
                        state   <= SCL_HIGH;
                        cnt     <= '0;
                        div_cur <= div_eff;
                    end
                end
                SCL_HIGH: begin
                    if (term) begin
                        cnt     <= '0;
                        div_cur <= div_eff;
                        if (en) begin
                            state    <= SCL_LOW;
                            SCL_OE   <= 1'b1;
                            scl_fall <= 1'b1;
                        end else begin
                            state <= SCL_IDLE;
                        end
                    end else begin
                        cnt        <= cnt + DIV_W'(1);
                        scl_sample <= (cnt + DIV_W'(1) == (div_cur >> 1));
                    end
                end
                SCL_LOW: begin
                    // Low always runs to terminal count so disabling never leaves a runt pulse.
                    if (term) begin
                        cnt     <= '0;
                        div_cur <= div_eff;
                        SCL_OE  <= 1'b0;
                        if (!en) begin
                            state <= SCL_IDLE;
                        end else if (!stretch_en) begin
                            state    <= SCL_HIGH;
                            scl_rise <= 1'b1;
                        end else begin
                            state <= SCL_WAIT_HI;
                        end
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                SCL_WAIT_HI: begin
                    if (!en) begin
                        state <= SCL_IDLE;
                    end else if (scl_sync) begin
                        state    <= SCL_HIGH;
                        scl_rise <= 1'b1;
                        cnt      <= '0;
                        div_cur  <= div_eff;
                    end
                end
                default: state <= SCL_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scl_clkgen.sv
// Directed bench for scl_clkgen: readbacks, period/strobe timing, clamp, stretch, disable, async reset.
module tb_scl_clkgen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] MDR = '0;
    logic        LD_SCLER = 1'b0;
    logic        LD_SCLDIV = 1'b0;
    logic        SCL_IN;
    logic        SCL_OE;
    logic        SCL_BUS;
    logic [15:0] SCLER;
    logic [15:0] SCLDIV;
    logic        WR;
    logic        scl_rise;
    logic        scl_fall;
    logic        scl_sample;
    logic        hold_low = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Open-drain pad model: line follows our own drive unless a slave holds it low.
    assign SCL_IN = ~SCL_OE & ~hold_low;

    scl_clkgen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .MDR        (MDR),
        .LD_SCLER   (LD_SCLER),
        .LD_SCLDIV  (LD_SCLDIV),
        .SCL_IN     (SCL_IN),
        .SCL_OE     (SCL_OE),
        .SCL_BUS    (SCL_BUS),
        .SCLER      (SCLER),
        .SCLDIV     (SCLDIV),
        .WR         (WR),
        .scl_rise   (scl_rise),
        .scl_fall   (scl_fall),
        .scl_sample (scl_sample)
    );

    task automatic write_scler(input logic [15:0] v);
        @(posedge clk); #1;
        MDR = v; LD_SCLER = 1'b1;
        @(posedge clk); #1;
        LD_SCLER = 1'b0; MDR = '0;
    endtask

    task automatic write_scldiv(input logic [15:0] v);
        @(posedge clk); #1;
        MDR = v; LD_SCLDIV = 1'b1;
        @(posedge clk); #1;
        LD_SCLDIV = 1'b0; MDR = '0;
    endtask

    task automatic wait_fall(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (scl_fall) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!SCLER[2]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (SCLER !== 16'h0000) begin errors++; $display("FAIL reset_scler: got %h expected 0000", SCLER); end
        checks++; if (SCLDIV !== 16'h01F4) begin errors++; $display("FAIL reset_scldiv: got %h expected 01f4", SCLDIV); end
        checks++; if (SCL_BUS !== 1'b1 || SCL_OE !== 1'b0) begin errors++; $display("FAIL reset_scl: got bus=%b oe=%b expected bus=1 oe=0", SCL_BUS, SCL_OE); end
        checks++; if ({WR, scl_rise, scl_fall, scl_sample} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {WR, scl_rise, scl_fall, scl_sample}); end
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (SCLER !== 16'h0000) begin errors++; $display("FAIL reset_idle: got %h expected 0000", SCLER); end
    endtask

    task automatic test_write;
        write_scldiv(16'd4);
        @(negedge clk);
        checks++; if (WR !== 1'b1) begin errors++; $display("FAIL write_wr_pulse: got %b expected 1", WR); end
        checks++; if (SCLDIV !== 16'd4) begin errors++; $display("FAIL write_scldiv: got %h expected 0004", SCLDIV); end
        @(negedge clk);
        checks++; if (WR !== 1'b0) begin errors++; $display("FAIL write_wr_clear: got %b expected 0", WR); end
    endtask

    task automatic test_period;
        int  last_fall, last_rise, nfall, nrise;
        bit  ok;
        last_fall = -1; last_rise = -1; nfall = 0; nrise = 0;
        write_scler(16'h0001);
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (scl_fall) begin
                if (last_fall >= 0) begin
                    checks++; if (i - last_fall != 8) begin errors++; $display("FAIL period_fall_interval: got %0d expected 8", i - last_fall); end
                end
                if (last_rise >= 0) begin
                    checks++; if (i - last_rise != 4) begin errors++; $display("FAIL period_high_len: got %0d expected 4", i - last_rise); end
                end
                checks++; if (SCL_OE !== 1'b1) begin errors++; $display("FAIL period_fall_oe: got %b expected 1", SCL_OE); end
                last_fall = i; nfall++;
            end
            if (scl_rise) begin
                checks++; if (i - last_fall != 4) begin errors++; $display("FAIL period_low_len: got %0d expected 4", i - last_fall); end
                last_rise = i; nrise++;
            end
            if (scl_sample && last_rise >= 0) begin
                checks++; if (i - last_rise != 2) begin errors++; $display("FAIL period_sample_pos: got %0d expected 2", i - last_rise); end
            end
        end
        checks++; if (nfall != 6) begin errors++; $display("FAIL period_fall_count: got %0d expected 6", nfall); end
        checks++; if (nrise != 5) begin errors++; $display("FAIL period_rise_count: got %0d expected 5", nrise); end
        write_scler(16'h0000);
        wait_idle(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL period_stop: got busy expected idle"); end
    endtask

    task automatic test_clamp;
        logic [15:0] dv;
        int  last_fall, last_rise, nfall;
        bit  ok;
        for (int d = 0; d < 2; d++) begin
            dv = 16'(d);
            last_fall = -1; last_rise = -1; nfall = 0;
            write_scldiv(dv);
            write_scler(16'h0001);
            for (int i = 0; i < 24; i++) begin
                @(negedge clk);
                if (scl_fall) begin
                    if (last_rise >= 0) begin
                        checks++; if (i - last_rise != 2) begin errors++; $display("FAIL clamp_high_len div=%0d: got %0d expected 2", d, i - last_rise); end
                    end
                    last_fall = i; nfall++;
                end
                if (scl_rise) begin
                    checks++; if (i - last_fall != 2) begin errors++; $display("FAIL clamp_low_len div=%0d: got %0d expected 2", d, i - last_fall); end
                    last_rise = i;
                end
            end
            checks++; if (nfall != 6) begin errors++; $display("FAIL clamp_fall_count div=%0d: got %0d expected 6", d, nfall); end
            write_scler(16'h0000);
            wait_idle(20, ok);
            checks++; if (!ok) begin errors++; $display("FAIL clamp_stop div=%0d: got busy expected idle", d); end
        end
    endtask

    task automatic test_stretch;
        int  nstr, nwait, hcnt;
        bit  ok, seen_rise;
        nstr = 0; nwait = 0; hcnt = 1; seen_rise = 1'b0;
        write_scldiv(16'd4);
        write_scler(16'h0003);
        wait_fall(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stretch_first_fall: got none expected scl_fall"); end
        hold_low = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!SCL_OE) break;
        end
        // SCL_IN held low for 10 full cycles after LOW; the synchroniser adds 2 more cycles of stretch.
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (scl_rise) begin
                seen_rise = 1'b1;
                break;
            end
            if (SCLER[4]) nstr++;
            nwait++;
            if (k == 9) begin
                @(posedge clk); #1 hold_low = 1'b0;
            end
        end
        hold_low = 1'b0;
        checks++; if (!seen_rise) begin errors++; $display("FAIL stretch_rise: got none expected scl_rise"); end
        checks++; if (nstr != 12) begin errors++; $display("FAIL stretch_stretching_cycles: got %0d expected 12", nstr); end
        checks++; if (nwait != 13) begin errors++; $display("FAIL stretch_wait_cycles: got %0d expected 13", nwait); end
        checks++; if (SCLER[3] !== 1'b1) begin errors++; $display("FAIL stretch_sticky_set: got %b expected 1", SCLER[3]); end
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (scl_fall) break;
            hcnt++;
        end
        checks++; if (hcnt != 4) begin errors++; $display("FAIL stretch_high_len: got %0d expected 4", hcnt); end
        write_scler(16'h0008);
        @(negedge clk);
        checks++; if (SCLER[3] !== 1'b0) begin errors++; $display("FAIL stretch_sticky_clear: got %b expected 0", SCLER[3]); end
        wait_idle(20, ok);
        checks++; if (!ok || SCLER !== 16'h0000) begin errors++; $display("FAIL stretch_stop: got %h expected 0000", SCLER); end
    endtask

    task automatic test_disable;
        int  low_rest, nfall;
        bit  ok, first_rel;
        low_rest = 0; nfall = 0; first_rel = 1'b1;
        write_scldiv(16'd6);
        write_scler(16'h0001);
        wait_fall(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL disable_first_fall: got none expected scl_fall"); end
        write_scler(16'h0000);
        // The two low cycles spent inside the write are L0 and L1; four more are owed.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (SCL_OE) low_rest++;
            if (scl_fall) nfall++;
            if (!SCL_OE && first_rel) begin
                first_rel = 1'b0;
                checks++; if (SCLER[2] !== 1'b0) begin errors++; $display("FAIL disable_busy_drop: got %b expected 0", SCLER[2]); end
            end
        end
        checks++; if (low_rest != 4) begin errors++; $display("FAIL disable_low_len: got %0d expected 4", low_rest); end
        checks++; if (nfall != 0) begin errors++; $display("FAIL disable_extra_fall: got %0d expected 0", nfall); end
        checks++; if (SCL_BUS !== 1'b1) begin errors++; $display("FAIL disable_bus_high: got %b expected 1", SCL_BUS); end
    endtask

    task automatic test_async_reset;
        int  nfall;
        bit  ok;
        nfall = 0;
        write_scldiv(16'h0010);
        write_scler(16'h0001);
        wait_fall(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL areset_first_fall: got none expected scl_fall"); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (SCL_OE !== 1'b0 || SCL_BUS !== 1'b1) begin errors++; $display("FAIL areset_release: got oe=%b bus=%b expected oe=0 bus=1", SCL_OE, SCL_BUS); end
        @(posedge clk); #1 reset_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (scl_fall) nfall++;
        end
        checks++; if (SCLDIV !== 16'h01F4) begin errors++; $display("FAIL areset_scldiv: got %h expected 01f4", SCLDIV); end
        checks++; if (SCLER !== 16'h0000) begin errors++; $display("FAIL areset_scler: got %h expected 0000", SCLER); end
        checks++; if (nfall != 0 || SCL_OE !== 1'b0) begin errors++; $display("FAIL areset_idle: got falls=%0d oe=%b expected 0 0", nfall, SCL_OE); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_period();
        test_clamp();
        test_stretch();
        test_disable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
